ssd_mux_counter: RTL and testbench
==================================

Name: ssd_mux_counter

Overview:
Parametrised successor to the two-digit seven-segment demo top. Holds a DIGITS-wide BCD counter (up/down, loadable, enable), generates its own count and scan ticks from internal prescalers, and time-multiplexes the digits onto one segment bus with a one-hot digit select. Adds optional leading-zero blanking and a wrap pulse for cascading. The segment bus and digit select are always coherent, so no digit ever shows another digit's pattern. Sits between the board clock and the display pins.

Parameters:
DIGITS, 4, number of BCD digits / display positions (1..8)
SCAN_DIV, 50000, CLK cycles per scan tick (>=2)
COUNT_DIV, 25000000, CLK cycles per count tick (>=2)
DIV_W, 32, prescaler counter width; must hold max(SCAN_DIV, COUNT_DIV)-1

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous, active-low reset (0 = reset asserted)
en  in  1  count enable, sampled on count tick
up  in  1  1 = count up, 0 = count down
load  in  1  synchronous load strobe
load_val  in  4*DIGITS  BCD load value, digit 0 in [3:0]
blank_lz  in  1  1 = blank leading zeros
digit_sel  out  DIGITS  one-hot active-high digit enable, bit i = digit i
seg  out  7  {g,f,e,d,c,b,a}, active-high (1 = lit)
value  out  4*DIGITS  current BCD count, registered
wrap  out  1  one-cycle pulse on counter wrap

Behaviour:
- Reset (RST=0, async): prescalers=0, value=0, scan index=0, digit_sel=0, seg=7'h00, wrap=0. All outputs registered.
- Prescalers: free-running, count 0..DIV-1; tick is high for the one cycle where the count equals DIV-1, then the count returns to 0. They are unaffected by en or load. First scan tick occurs in cycle SCAN_DIV after reset release.
- Count step (count tick and en=1 and load=0):
  - Up: BCD ripple; a digit at 9 becomes 0 and carries. All digits at 9 -> all 0 with wrap=1 next cycle.
  - Down: BCD borrow; a digit at 0 becomes 9 and borrows. All digits at 0 -> all 9 with wrap=1.
- en=0 on a count tick: hold, wrap=0.
- Load: when load=1 in a cycle, value takes load_val on the next edge, whether or not a count tick is present (load wins over step). Any nibble >9 loads as 0. A load never asserts wrap.
- value updates one cycle after the qualifying tick or load.
- Scan: on each scan tick, scan index advances i -> i+1, wrapping DIGITS-1 -> 0. On that same edge:
  - digit_sel becomes one-hot(new index).
  - seg becomes the decode of value digit[new index] as it stands in the cycle of the tick.
  - Between scan ticks, digit_sel and seg hold.
- After reset, the first scan tick selects digit 1 (digit 0 if DIGITS=1).
- Decode: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex); any other code=00.
- Leading-zero blanking: with blank_lz=1, digit i (i>0) shows seg=00 when digits DIGITS-1 down to i are all 0. Digit 0 is never blanked. digit_sel still asserts for a blanked digit.
- Count tick and scan tick in the same cycle: both act. seg decodes the pre-update value.
- DIGITS=1: digit_sel constantly 1 after the first scan tick.

Test Plan:
- Reset/idle: DIGITS=2, SCAN_DIV=4, COUNT_DIV=10, hold RST=0 then release, en=0 -> digit_sel=00, seg=00 until cycle 4. Then digit_sel alternates 10/01 every 4 cycles with seg=3F.
- Up count and carry: en=1, up=1, load 09 -> after one count tick value=10, wrap=0. Load 99, one count tick -> value=00 and a single-cycle wrap=1.
- Down and borrow: up=0, load 10 -> one tick gives 09. Load 00 -> one tick gives 99 with wrap=1.
- Load priority and clamp: load=1 with load_val=8'hA5 in the count-tick cycle, en=1 -> value=05, no step, wrap=0.
- Blanking: DIGITS=4, load 0007, blank_lz=1 -> seg=00 for digits 3..1 and 07 for digit 0. blank_lz=0 -> 3F,3F,3F,07. Load 0000 with blank_lz=1 -> digit 0 shows 3F.
- Async reset mid-operation: assert RST=0 between clock edges while counting -> all outputs zero immediately without a clock edge. After release, counting restarts from 0000.

Source files
------------

// File: rtl/ssd_mux_counter.sv
// Multi-digit BCD up/down counter with internal count/scan prescalers,
// time-multiplexed onto one seven-segment bus with optional leading-zero blanking.
module ssd_mux_counter #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int COUNT_DIV = 25000000,
    parameter int DIV_W     = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [6:0]            seg,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap
);

    localparam int                IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0]  SCAN_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]  COUNT_LAST = DIV_W'(COUNT_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);

    function automatic logic [6:0] decode_f(input logic [3:0] d);
        case (d)
            4'd0:    decode_f = 7'h3F;
            4'd1:    decode_f = 7'h06;
            4'd2:    decode_f = 7'h5B;
            4'd3:    decode_f = 7'h4F;
            4'd4:    decode_f = 7'h66;
            4'd5:    decode_f = 7'h6D;
            4'd6:    decode_f = 7'h7D;
            4'd7:    decode_f = 7'h07;
            4'd8:    decode_f = 7'h7F;
            4'd9:    decode_f = 7'h6F;
            default: decode_f = 7'h00;
        endcase
    endfunction

    logic [DIV_W-1:0]    scan_cnt_r;
    logic [DIV_W-1:0]    count_cnt_r;
    logic [IDX_W-1:0]    scan_idx_r;
    logic [4*DIGITS-1:0] value_r;
    logic [DIGITS-1:0]   digit_sel_r;
    logic [6:0]          seg_r;
    logic                wrap_r;

    logic                scan_tick_s;
    logic                count_tick_s;
    logic                step_s;
    logic                carry_s;
    logic [4*DIGITS-1:0] step_val_s;
    logic [4*DIGITS-1:0] load_clamp_s;
    logic [DIGITS-1:0]   lz_s;
    logic                zero_run_s;
    logic [IDX_W-1:0]    scan_next_s;
    logic [DIGITS-1:0]   sel_next_s;
    logic [6:0]          seg_next_s;

    assign scan_tick_s  = (scan_cnt_r == SCAN_LAST);
    assign count_tick_s = (count_cnt_r == COUNT_LAST);
    assign step_s       = count_tick_s & en & ~load;

    // BCD ripple step; carry_s ends high only when every digit rolled over
    always_comb begin
        carry_s    = 1'b1;
        step_val_s = value_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry_s) begin
                if (up) begin
                    if (value_r[4*i +: 4] == 4'd9) begin
                        step_val_s[4*i +: 4] = 4'd0;
                    end else begin
                        step_val_s[4*i +: 4] = value_r[4*i +: 4] + 4'd1;
                        carry_s = 1'b0;
                    end
                end else begin
                    if (value_r[4*i +: 4] == 4'd0) begin
                        step_val_s[4*i +: 4] = 4'd9;
                    end else begin
                        step_val_s[4*i +: 4] = value_r[4*i +: 4] - 4'd1;
                        carry_s = 1'b0;
                    end
                end
            end else begin
                step_val_s[4*i +: 4] = value_r[4*i +: 4];
            end
        end
    end

    // Non-BCD load nibbles are forced to zero
    always_comb begin
        load_clamp_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_clamp_s[4*i +: 4] = 4'd0;
            end else begin
                load_clamp_s[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    // lz_s[i] set when digits DIGITS-1 down to i are all zero
    always_comb begin
        zero_run_s = 1'b1;
        lz_s       = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run_s = zero_run_s & (value_r[4*i +: 4] == 4'd0);
            lz_s[i]    = zero_run_s;
        end
    end

    // Next scan position and the segment pattern it will show
    always_comb begin
        sel_next_s = '0;
        if (scan_idx_r == IDX_LAST) begin
            scan_next_s = '0;
        end else begin
            scan_next_s = scan_idx_r + IDX_W'(1);
        end
        sel_next_s[scan_next_s] = 1'b1;
        if (blank_lz && (scan_next_s != '0) && lz_s[scan_next_s]) begin
            seg_next_s = 7'h00;
        end else begin
            seg_next_s = decode_f(value_r[4*int'(scan_next_s) +: 4]);
        end
    end

    // Free-running prescalers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            scan_cnt_r  <= '0;
            count_cnt_r <= '0;
        end else begin
            scan_cnt_r  <= scan_tick_s  ? '0 : scan_cnt_r  + DIV_W'(1);
            count_cnt_r <= count_tick_s ? '0 : count_cnt_r + DIV_W'(1);
        end
    end

    // Counter value and wrap pulse; load has priority over a step
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            value_r <= '0;
            wrap_r  <= 1'b0;
        end else if (load) begin
            value_r <= load_clamp_s;
            wrap_r  <= 1'b0;
        end else if (step_s) begin
            value_r <= step_val_s;
            wrap_r  <= carry_s;
        end else begin
            wrap_r  <= 1'b0;
        end
    end

    // Scan position, digit select and segments update together so they stay coherent
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            scan_idx_r  <= '0;
            digit_sel_r <= '0;
            seg_r       <= 7'h00;
        end else if (scan_tick_s) begin
            scan_idx_r  <= scan_next_s;
            digit_sel_r <= sel_next_s;
            seg_r       <= seg_next_s;
        end
    end

    assign digit_sel = digit_sel_r;
    assign seg       = seg_r;
    assign value     = value_r;
    assign wrap      = wrap_r;

endmodule

// File: tb/tb_ssd_mux_counter.sv
// Directed bench for ssd_mux_counter: 2-digit, 4-digit and 1-digit instances
// sharing clock and controls, with expectations derived from the edge count.
module tb_ssd_mux_counter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        en = 1'b0, up = 1'b1, load = 1'b0, blank_lz = 1'b0;
    logic [7:0]  lv2 = 8'h00;
    logic [15:0] lv4 = 16'h0000;
    logic [3:0]  lv1 = 4'h0;
    logic [1:0]  ds2;  logic [6:0] seg2; logic [7:0]  val2; logic wrap2;
    logic [3:0]  ds4;  logic [6:0] seg4; logic [15:0] val4; logic wrap4;
    logic [0:0]  ds1;  logic [6:0] seg1; logic [3:0]  val1; logic wrap1;

    int checks = 0;
    int fails  = 0;
    int edge_cnt = 0;
    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    ssd_mux_counter #(.DIGITS(2), .SCAN_DIV(4), .COUNT_DIV(10), .DIV_W(8)) dut2 (
        .CLK(CLK), .RST(RST), .en(en), .up(up), .load(load), .load_val(lv2),
        .blank_lz(blank_lz), .digit_sel(ds2), .seg(seg2), .value(val2), .wrap(wrap2));
    ssd_mux_counter #(.DIGITS(4), .SCAN_DIV(4), .COUNT_DIV(10), .DIV_W(8)) dut4 (
        .CLK(CLK), .RST(RST), .en(en), .up(up), .load(load), .load_val(lv4),
        .blank_lz(blank_lz), .digit_sel(ds4), .seg(seg4), .value(val4), .wrap(wrap4));
    ssd_mux_counter #(.DIGITS(1), .SCAN_DIV(4), .COUNT_DIV(10), .DIV_W(8)) dut1 (
        .CLK(CLK), .RST(RST), .en(en), .up(up), .load(load), .load_val(lv1),
        .blank_lz(blank_lz), .digit_sel(ds1), .seg(seg1), .value(val1), .wrap(wrap1));

    always #5 CLK = ~CLK;

    task automatic adv(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            edge_cnt++;
            @(negedge CLK);
        end
    endtask

    task automatic to_count_tick();
        do adv(1); while (edge_cnt % 10 != 0);
    endtask

    task automatic to_scan_tick();
        do adv(1); while (edge_cnt % 4 != 0);
    endtask

    task automatic do_load2(input logic [7:0] v);
        lv2 = v; load = 1'b1;
        adv(1);
        load = 1'b0;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; en = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1; edge_cnt = 0;
        checks++;
        if (ds2 !== 2'b00 || seg2 !== 7'h00 || val2 !== 8'h00 || wrap2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: sel=%b seg=%h val=%h wrap=%b", ds2, seg2, val2, wrap2);
        end
        adv(3);
        chk("idle_sel_before_tick", {14'd0, ds2}, 16'h0000);
        chk("idle_seg_before_tick", {9'd0, seg2}, 16'h0000);
        adv(1);
        chk("first_scan_sel", {14'd0, ds2}, 16'h0002);
        chk("first_scan_seg", {9'd0, seg2}, 16'h003F);
        chk("d1_first_scan_sel", {15'd0, ds1}, 16'h0001);
        chk("d4_first_scan_sel", {12'd0, ds4}, 16'h0002);
        adv(3);
        chk("hold_between_ticks", {14'd0, ds2}, 16'h0002);
        adv(1);
        chk("second_scan_sel", {14'd0, ds2}, 16'h0001);
        chk("second_scan_seg", {9'd0, seg2}, 16'h003F);
        adv(4);
        chk("d1_sel_constant", {15'd0, ds1}, 16'h0001);
    endtask

    task automatic test_up_count();
        en = 1'b1; up = 1'b1;
        do_load2(8'h09);
        to_count_tick();
        chk("up_carry_val", {8'd0, val2}, 16'h0010);
        chk("up_carry_wrap", {15'd0, wrap2}, 16'h0000);
        do_load2(8'h99);
        to_count_tick();
        chk("up_wrap_val", {8'd0, val2}, 16'h0000);
        chk("up_wrap_pulse", {15'd0, wrap2}, 16'h0001);
        adv(1);
        chk("up_wrap_single", {15'd0, wrap2}, 16'h0000);
    endtask

    task automatic test_down_count();
        en = 1'b1; up = 1'b0;
        do_load2(8'h10);
        to_count_tick();
        chk("down_borrow_val", {8'd0, val2}, 16'h0009);
        chk("down_borrow_wrap", {15'd0, wrap2}, 16'h0000);
        do_load2(8'h00);
        to_count_tick();
        chk("down_wrap_val", {8'd0, val2}, 16'h0099);
        chk("down_wrap_pulse", {15'd0, wrap2}, 16'h0001);
        en = 1'b0;
        to_count_tick();
        chk("en0_hold_val", {8'd0, val2}, 16'h0099);
        chk("en0_no_wrap", {15'd0, wrap2}, 16'h0000);
    endtask

    task automatic test_load_priority();
        en = 1'b1; up = 1'b1;
        do_load2(8'h99);
        while (edge_cnt % 10 != 9) adv(1);
        do_load2(8'hA5);
        chk("load_prio_val", {8'd0, val2}, 16'h0005);
        chk("load_prio_wrap", {15'd0, wrap2}, 16'h0000);
        en = 1'b0;
    endtask

    task automatic scan_check(input string name, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] exp_seg;
        int idx;
        for (int k = 0; k < 4; k++) begin
            to_scan_tick();
            idx = (edge_cnt / 4) % 4;
            case (idx)
                0:       exp_seg = e0;
                1:       exp_seg = e1;
                2:       exp_seg = e2;
                default: exp_seg = e3;
            endcase
            chk({name, "_sel"}, {12'd0, ds4}, 16'(4'b0001 << idx));
            chk({name, "_seg"}, {9'd0, seg4}, {9'd0, exp_seg});
        end
    endtask

    task automatic test_blanking();
        en = 1'b0;
        lv4 = 16'h0007; load = 1'b1;
        adv(1);
        load = 1'b0;
        blank_lz = 1'b1;
        scan_check("blank_0007", seg_tab[7], 7'h00, 7'h00, 7'h00);
        blank_lz = 1'b0;
        scan_check("noblank_0007", seg_tab[7], seg_tab[0], seg_tab[0], seg_tab[0]);
        lv4 = 16'h0000; load = 1'b1;
        adv(1);
        load = 1'b0;
        blank_lz = 1'b1;
        scan_check("blank_0000", seg_tab[0], 7'h00, 7'h00, 7'h00);
        blank_lz = 1'b0;
    endtask

    task automatic test_async_reset();
        en = 1'b1; up = 1'b1;
        do_load2(8'h37);
        adv(6);
        #2 RST = 1'b0;
        #1;
        checks++;
        if (ds2 !== 2'b00 || seg2 !== 7'h00 || val2 !== 8'h00 || wrap2 !== 1'b0 ||
            ds4 !== 4'b0000 || val4 !== 16'h0000) begin
            fails++;
            $display("FAIL async_reset: sel=%b seg=%h val=%h wrap=%b sel4=%b val4=%h",
                     ds2, seg2, val2, wrap2, ds4, val4);
        end
        @(negedge CLK);
        RST = 1'b1; edge_cnt = 0;
        adv(9);
        chk("restart_before_tick", {8'd0, val2}, 16'h0000);
        adv(1);
        chk("restart_first_count", {8'd0, val2}, 16'h0001);
        chk("restart_first_count4", val4, 16'h0001);
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_count();
        test_load_priority();
        test_blanking();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
